control_sequencer: RTL

- Multi-cycle control FSM for the Mini SRC datapath.
- Consumes the 5-bit opcode produced by the register select/encode logic.
- Drives that logic's inputs (Gra/Grb/Grc/Rin/Rout/BAout) plus all datapath strobes, one micro-step per clock.
- Sequences fetch (T0–T2) and a per-opcode execute phase (T3–T7), then returns to T0.

---
 rtl/mini_src_pkg.sv | 91 +++++++++
 rtl/cs_step_decode.sv | 138 +++++++++++++
 rtl/control_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mini_src_pkg.sv
// Mini SRC control unit: opcode map, ALU codes, step encoding, control bundle.
package mini_src_pkg;

    localparam int OP_W   = 5;
    localparam int STEP_W = 4;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BRX  = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;
    localparam logic [OP_W-1:0] ALU_AND = OP_AND;
    localparam logic [OP_W-1:0] ALU_OR  = OP_OR;

    typedef enum logic [STEP_W-1:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } step_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY,
        C_BRX, C_JR, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } class_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout;
        logic pcout, pcin, incpc;
        logic marin, mdrin, mdrout, read, write;
        logic irin, yin, zin, zhighout, zlowout, cout;
        logic hiin, loin, hiout, loout, conin;
        logic [OP_W-1:0] alu_op;
        logic illegal;
    } ctrl_t;

    function automatic class_t op_class(input logic [OP_W-1:0] op);
        class_t c;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  c = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:         c = C_IMM;
            OP_LDI:                           c = C_LDI;
            OP_LD:                            c = C_LD;
            OP_ST:                            c = C_ST;
            OP_MUL, OP_DIV:                   c = C_MULDIV;
            OP_NEG, OP_NOT:                   c = C_UNARY;
            OP_BRX:                           c = C_BRX;
            OP_JR:                            c = C_JR;
            OP_MFHI:                          c = C_MFHI;
            OP_MFLO:                          c = C_MFLO;
            OP_NOP:                           c = C_NOP;
            OP_HALT:                          c = C_HALT;
            default:                          c = C_ILL;
        endcase
        return c;
    endfunction

    // Final execute step of each instruction class.
    function automatic step_t last_step(input class_t c);
        step_t s;
        unique case (c)
            C_UNARY:                s = T4;
            C_RTYPE, C_IMM, C_LDI:  s = T5;
            C_MULDIV, C_BRX:        s = T6;
            C_LD, C_ST:             s = T7;
            default:                s = T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cs_step_decode.sv
// Combinational micro-step decoder: (step, opcode, con) -> control strobes.
module cs_step_decode
    import mini_src_pkg::*;
(
    input  step_t            step,
    input  logic [OP_W-1:0]  opcode,
    input  logic             con,
    output ctrl_t            ctrl
);

    class_t cls;
    logic [OP_W-1:0] imm_alu;

    assign cls = op_class(opcode);
    assign imm_alu = (opcode == OP_ADDI) ? ALU_ADD :
                     (opcode == OP_ANDI) ? ALU_AND : ALU_OR;

    always_comb begin
        ctrl = '0;
        unique case (step)
            T0: begin
                ctrl.pcout = 1'b1; ctrl.marin = 1'b1;
                ctrl.incpc = 1'b1; ctrl.zin   = 1'b1;
            end
            T1: begin
                ctrl.zlowout = 1'b1; ctrl.pcin  = 1'b1;
                ctrl.read    = 1'b1; ctrl.mdrin = 1'b1;
            end
            T2: begin
                ctrl.mdrout = 1'b1; ctrl.irin = 1'b1;
            end
            T3: begin
                unique case (cls)
                    C_RTYPE, C_IMM: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_BRX: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1;
                    end
                    C_JR: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    C_MFLO: begin
                        ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    C_ILL:   ctrl.illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                unique case (cls)
                    C_RTYPE: begin
                        ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_IMM: begin
                        ctrl.cout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = imm_alu;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl.cout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    C_MULDIV: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_UNARY: begin
                        ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    C_BRX: begin
                        ctrl.pcout = 1'b1; ctrl.yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                unique case (cls)
                    C_RTYPE, C_IMM, C_LDI: begin
                        ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ctrl.zlowout = 1'b1; ctrl.marin = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl.zlowout = 1'b1; ctrl.loin = 1'b1;
                    end
                    C_BRX: begin
                        ctrl.cout = 1'b1; ctrl.zin = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            T6: begin
                unique case (cls)
                    C_LD: begin
                        ctrl.read = 1'b1; ctrl.mdrin = 1'b1;
                    end
                    C_ST: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrin = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl.zhighout = 1'b1; ctrl.hiin = 1'b1;
                    end
                    C_BRX: begin
                        ctrl.zlowout = 1'b1; ctrl.pcin = con;
                    end
                    default: ;
                endcase
            end
            T7: begin
                unique case (cls)
                    C_LD: begin
                        ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    C_ST:    ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC multi-cycle control sequencer (fetch T0-T2, execute T3-T7, HALT).
// Define CU_MEM_WAIT_EN to stall memory steps on the mem_ready handshake.
module control_sequencer
    import mini_src_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            con,
    input  logic            mem_ready,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            Cout,
    output logic            HIin,
    output logic            LOin,
    output logic            HIout,
    output logic            LOout,
    output logic            CONin,
    output logic [OP_W-1:0] alu_op,
    output logic            run,
    output logic            illegal
);

    step_t  state;
    step_t  state_nxt;
    step_t  last;
    class_t cls;
    ctrl_t  ctrl;
    ctrl_t  o;
    logic   armed;
    logic   mem_step;
    logic   hold;

    assign cls  = op_class(opcode);
    assign last = last_step(cls);
    assign mem_step = (state == T1) ||
                      (state == T6 && cls == C_LD) ||
                      (state == T7 && cls == C_ST);

`ifdef CU_MEM_WAIT_EN
    assign hold = mem_step && !mem_ready;
`else
    logic unused_mem;
    assign unused_mem = mem_ready & mem_step;
    assign hold = 1'b0;
`endif

    // armed keeps strobes quiet until the first edge after reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (armed && !hold) begin
            unique case (state)
                T0: state_nxt = T1;
                T1: state_nxt = T2;
                T2: state_nxt = (cls == C_NOP)  ? T0 :
                                (cls == C_HALT) ? HALT : T3;
                T3: state_nxt = (last == T3) ? T0 : T4;
                T4: state_nxt = (last == T4) ? T0 : T5;
                T5: state_nxt = (last == T5) ? T0 : T6;
                T6: state_nxt = (last == T6) ? T0 : T7;
                T7: state_nxt = T0;
                default: state_nxt = HALT;
            endcase
        end
    end

    cs_step_decode u_decode (
        .step   (state),
        .opcode (opcode),
        .con    (con),
        .ctrl   (ctrl)
    );

    always_comb begin
        o        = armed ? ctrl : '0;
        Gra      = o.gra;
        Grb      = o.grb;
        Grc      = o.grc;
        Rin      = o.rin;
        Rout     = o.rout;
        BAout    = o.baout;
        PCout    = o.pcout;
        PCin     = o.pcin;
        IncPC    = o.incpc;
        MARin    = o.marin;
        MDRin    = o.mdrin;
        MDRout   = o.mdrout;
        Read     = o.read;
        Write    = o.write;
        IRin     = o.irin;
        Yin      = o.yin;
        Zin      = o.zin;
        Zhighout = o.zhighout;
        Zlowout  = o.zlowout;
        Cout     = o.cout;
        HIin     = o.hiin;
        LOin     = o.loin;
        HIout    = o.hiout;
        LOout    = o.loout;
        CONin    = o.conin;
        alu_op   = o.alu_op;
        illegal  = o.illegal;
        run      = (state != HALT);
    end

endmodule
